// File: rtl/hazard_ctrl_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the RV32 hazard controller.
//               It holds the load-use FSM state encoding, the decoder opcode
//               constants and the default sequential PC increment.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Load-use FSM state encoding
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    LU_WAIT = 1'b1
  } lu_state_e;

  // Opcode constants for the decoders that feed this block
  localparam logic [6:0] OP_LOAD       = 7'b0000011;
  localparam logic [2:0] OP_BRANCH_GRP = 3'b110;

  // Sequential PC increment for 32-bit instructions
  localparam int PC_INC_DEFAULT = 4;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_mc_mc_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : mc_scoreboard
// Description : Scoreboard for one non-pipelined multi-cycle unit (mul/div).
//               It tracks the busy flag, the remaining latency and the
//               destination of the in-flight op, and it raises a stall on a
//               RAW hit or a structural conflict.
// Ports       : clk, rst           - clock, async active-high reset
//               i_id_*             - ID-stage source/use/mc qualifiers
//               i_ex_*             - EX-stage issue information
//               i_redirect         - EX redirect this cycle (blocks issue)
//               o_busy             - unit occupied
//               o_stall            - RAW or structural stall request
// Revision    : 1.0 - initial release
// ============================================================================
module mc_scoreboard #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic              i_id_is_mc,
  input  logic              i_ex_valid,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_wen,
  input  logic              i_ex_is_mc,
  input  logic              i_redirect,
  output logic              o_busy,
  output logic              o_stall
);

  localparam int MC_CW = $clog2(MC_LAT);

  logic [MC_CW-1:0]  r_cnt;
  logic              r_busy;
  logic [REG_AW-1:0] r_rd;

  logic w_issue;
  logic w_ex_mc;
  logic w_raw_inflight;
  logic w_raw_issue;
  logic w_struct;

  // x0 never hazards, so a zero index is a miss by construction
  function automatic logic f_src_hit(input logic              valid,
                                     input logic              use_rs,
                                     input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] r);
    return valid & use_rs & (rs != '0) & (rs == r);
  endfunction

  assign w_ex_mc = i_ex_valid & i_ex_is_mc;
  assign w_issue = w_ex_mc & ~i_redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rd   <= '0;
    end else if (w_issue) begin
      r_busy <= 1'b1;
      r_cnt  <= MC_CW'(MC_LAT - 1);
      r_rd   <= i_ex_wen ? i_ex_rd : '0;
    end else if (r_busy) begin
      // Busy drops on the edge where the counter has reached zero,
      // so the unit reads busy for exactly MC_LAT cycles
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - MC_CW'(1);
      end
    end
  end

  assign w_raw_inflight = r_busy & (r_rd != '0) &
                          (f_src_hit(i_id_valid, i_id_use_rs1, i_id_rs1, r_rd) |
                           f_src_hit(i_id_valid, i_id_use_rs2, i_id_rs2, r_rd));

  assign w_raw_issue = w_ex_mc & i_ex_wen &
                       (f_src_hit(i_id_valid, i_id_use_rs1, i_id_rs1, i_ex_rd) |
                        f_src_hit(i_id_valid, i_id_use_rs2, i_id_rs2, i_ex_rd));

  assign w_struct = i_id_valid & i_id_is_mc & (r_busy | w_ex_mc);

  assign o_busy  = r_busy;
  assign o_stall = w_raw_inflight | w_raw_issue | w_struct;

endmodule : mc_scoreboard
`default_nettype wire

// File: rtl/hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_mc
// Description : Pipeline hazard controller for the 5-stage RV32 core.
//               Load-use stalls with configurable latency, a multi-cycle unit
//               scoreboard, and branch/jump redirect that overrides stalls.
// Ports       : clk, rst                 - clock, async active-high reset
//               id_*                     - ID-stage instruction info
//               ex_*                     - EX-stage instruction info
//               stall_pc, stall_id       - hold PC / IF-ID register
//               flush_id, flush_ex       - zero IF-ID / ID-EX register
//               redirect_valid/_pc       - fetch redirect request/address
//               mc_busy                  - multi-cycle unit occupied
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MC_LAT   = 4,
  parameter int PC_INC   = PC_INC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_is_mc,
  input  logic [XLEN-1:0]   id_pc,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wen,
  input  logic              ex_is_load,
  input  logic              ex_is_mc,
  input  logic              ex_is_ctrl,
  input  logic              ex_taken,
  input  logic [XLEN-1:0]   ex_target,
  input  logic [XLEN-1:0]   ex_pc,
  output logic              stall_pc,
  output logic              stall_id,
  output logic              flush_id,
  output logic              flush_ex,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              mc_busy
);

  localparam int LU_CW = 3;

  lu_state_e        r_state;
  lu_state_e        w_state_nxt;
  logic [LU_CW-1:0] r_lu_cnt;
  logic [LU_CW-1:0] w_lu_cnt_nxt;

  logic            w_lu_det;
  logic            w_lu_stall;
  logic            w_mc_stall;
  logic            w_mc_busy;
  logic            w_stall_any;
  logic [XLEN-1:0] w_seq_pc;
  logic [XLEN-1:0] w_actual;
  logic            w_redirect;

  function automatic logic f_src_hit(input logic              valid,
                                     input logic              use_rs,
                                     input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] r);
    return valid & use_rs & (rs != '0) & (rs == r);
  endfunction

  // --------------------------------------------------------------------------
  // Redirect compare: the XLEN-wide add wraps naturally past the top of memory
  // --------------------------------------------------------------------------
  assign w_seq_pc   = ex_pc + XLEN'(PC_INC);
  assign w_actual   = ex_taken ? ex_target : w_seq_pc;
  assign w_redirect = ex_valid & ex_is_ctrl & (~id_valid | (w_actual != id_pc));

  // --------------------------------------------------------------------------
  // Load-use detection and FSM
  // --------------------------------------------------------------------------
  assign w_lu_det = ex_valid & ex_is_load & ex_wen &
                    (f_src_hit(id_valid, id_use_rs1, id_rs1, ex_rd) |
                     f_src_hit(id_valid, id_use_rs2, id_rs2, ex_rd));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_lu_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_lu_cnt <= w_lu_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_lu_cnt_nxt = r_lu_cnt;
    if (w_redirect) begin
      // A younger-than-branch stall sequence is abandoned
      w_state_nxt  = IDLE;
      w_lu_cnt_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          // The detect cycle is itself the first bubble
          if (w_lu_det && (LOAD_LAT > 1)) begin
            w_state_nxt  = LU_WAIT;
            w_lu_cnt_nxt = LU_CW'(LOAD_LAT - 1);
          end
        end
        LU_WAIT: begin
          if (r_lu_cnt == LU_CW'(1)) begin
            w_state_nxt  = IDLE;
            w_lu_cnt_nxt = '0;
          end else begin
            w_lu_cnt_nxt = r_lu_cnt - LU_CW'(1);
          end
        end
        default: begin
          w_state_nxt  = IDLE;
          w_lu_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_lu_stall = 1'b0;
    case (r_state)
      IDLE:    w_lu_stall = w_lu_det;
      LU_WAIT: w_lu_stall = 1'b1;
      default: w_lu_stall = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Multi-cycle unit scoreboard
  // --------------------------------------------------------------------------
  mc_scoreboard #(
    .REG_AW (REG_AW),
    .MC_LAT (MC_LAT)
  ) u_mc_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .i_id_valid   (id_valid),
    .i_id_rs1     (id_rs1),
    .i_id_rs2     (id_rs2),
    .i_id_use_rs1 (id_use_rs1),
    .i_id_use_rs2 (id_use_rs2),
    .i_id_is_mc   (id_is_mc),
    .i_ex_valid   (ex_valid),
    .i_ex_rd      (ex_rd),
    .i_ex_wen     (ex_wen),
    .i_ex_is_mc   (ex_is_mc),
    .i_redirect   (w_redirect),
    .o_busy       (w_mc_busy),
    .o_stall      (w_mc_stall)
  );

  // --------------------------------------------------------------------------
  // Output merge: redirect wins over every stall; everything is held low
  // during reset, including the combinational redirect address
  // --------------------------------------------------------------------------
  assign w_stall_any = w_lu_stall | w_mc_stall;

  always_comb begin
    stall_pc       = 1'b0;
    stall_id       = 1'b0;
    flush_id       = 1'b0;
    flush_ex       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mc_busy        = 1'b0;
    if (!rst) begin
      redirect_pc    = w_actual;
      redirect_valid = w_redirect;
      mc_busy        = w_mc_busy;
      if (w_redirect) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (w_stall_any) begin
        stall_pc = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
    end
  end

endmodule : hazard_ctrl_mc
`default_nettype wire

// File: tb/tb_hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl_mc
// Description : Directed self-checking bench for hazard_ctrl_mc. Two copies
//               share the stimulus: one with LOAD_LAT=1, one with LOAD_LAT=3,
//               both with MC_LAT=4. Output vectors are packed as
//               {stall_pc, stall_id, flush_id, flush_ex, redirect_valid, mc_busy}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_mc;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic        id_is_mc;
  logic [31:0] id_pc;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_wen;
  logic        ex_is_load;
  logic        ex_is_mc;
  logic        ex_is_ctrl;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic [31:0] ex_pc;

  logic        sp1, sid1, fid1, fex1, rv1, bz1;
  logic [31:0] rpc1;
  logic        sp3, sid3, fid3, fex3, rv3, bz3;
  logic [31:0] rpc3;

  logic [5:0] w_o1;
  logic [5:0] w_o3;
  assign w_o1 = {sp1, sid1, fid1, fex1, rv1, bz1};
  assign w_o3 = {sp3, sid3, fid3, fex3, rv3, bz3};

  int checks;
  int failures;

  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] STALL = 6'b110100;
  localparam logic [5:0] STB   = 6'b110101;
  localparam logic [5:0] REDIR = 6'b001110;
  localparam logic [5:0] RDB   = 6'b001111;
  localparam logic [5:0] BUSY  = 6'b000001;

  hazard_ctrl_mc #(.XLEN(32), .REG_AW(5), .LOAD_LAT(1), .MC_LAT(4), .PC_INC(4)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_is_mc(id_is_mc), .id_pc(id_pc),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
    .ex_is_mc(ex_is_mc), .ex_is_ctrl(ex_is_ctrl), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pc(ex_pc), .stall_pc(sp1), .stall_id(sid1),
    .flush_id(fid1), .flush_ex(fex1), .redirect_valid(rv1), .redirect_pc(rpc1),
    .mc_busy(bz1));

  hazard_ctrl_mc #(.XLEN(32), .REG_AW(5), .LOAD_LAT(3), .MC_LAT(4), .PC_INC(4)) dut3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_is_mc(id_is_mc), .id_pc(id_pc),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
    .ex_is_mc(ex_is_mc), .ex_is_ctrl(ex_is_ctrl), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pc(ex_pc), .stall_pc(sp3), .stall_id(sid3),
    .flush_id(fid3), .flush_ex(fex3), .redirect_valid(rv3), .redirect_pc(rpc3),
    .mc_busy(bz3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then settle just past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_is_mc = 0; id_pc = 0;
    ex_valid = 0; ex_rd = 0; ex_wen = 0; ex_is_load = 0; ex_is_mc = 0;
    ex_is_ctrl = 0; ex_taken = 0; ex_target = 0; ex_pc = 0;
  endtask

  task automatic ex_clear();
    ex_valid = 0; ex_rd = 0; ex_wen = 0; ex_is_load = 0; ex_is_mc = 0;
    ex_is_ctrl = 0; ex_taken = 0; ex_target = 0; ex_pc = 0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr_inputs();
    rst = 1'b1;

    // ---- Reset: outputs low even with a redirecting branch in EX ----
    ex_valid = 1; ex_is_ctrl = 1; ex_taken = 1; ex_target = 32'h80; ex_pc = 32'h100;
    #2;
    chk("rst_out1", {26'd0, w_o1}, {26'd0, NONE});
    chk("rst_out3", {26'd0, w_o3}, {26'd0, NONE});
    chk("rst_rpc1", rpc1, 32'h0);
    step();
    step();
    rst = 1'b0;
    clr_inputs();
    #1;
    chk("idle1", {26'd0, w_o1}, {26'd0, NONE});

    // ---- Load-use, x5: 1 bubble on dut1, 3 bubbles on dut3 ----
    ex_valid = 1; ex_is_load = 1; ex_wen = 1; ex_rd = 5;
    id_valid = 1; id_use_rs1 = 1; id_rs1 = 5; id_pc = 32'h200;
    #1;
    chk("lu_c1_d1", {26'd0, w_o1}, {26'd0, STALL});
    chk("lu_c1_d3", {26'd0, w_o3}, {26'd0, STALL});
    step();
    ex_clear();
    #1;
    chk("lu_c2_d1", {26'd0, w_o1}, {26'd0, NONE});
    chk("lu_c2_d3", {26'd0, w_o3}, {26'd0, STALL});
    step();
    chk("lu_c3_d3", {26'd0, w_o3}, {26'd0, STALL});
    step();
    chk("lu_c4_d3", {26'd0, w_o3}, {26'd0, NONE});

    // ---- Load-use via rs2 ----
    id_use_rs1 = 0; id_use_rs2 = 1; id_rs2 = 5;
    ex_valid = 1; ex_is_load = 1; ex_wen = 1; ex_rd = 5;
    #1;
    chk("lu_rs2_d1", {26'd0, w_o1}, {26'd0, STALL});
    step();
    ex_clear();
    step();
    step();
    chk("lu_rs2_done", {26'd0, w_o3}, {26'd0, NONE});

    // ---- x0 and operand-use qualification ----
    ex_valid = 1; ex_is_load = 1; ex_wen = 1; ex_rd = 0;
    id_use_rs1 = 1; id_rs1 = 0; id_use_rs2 = 0; id_rs2 = 0;
    #1;
    chk("lu_x0_d3", {26'd0, w_o3}, {26'd0, NONE});
    ex_rd = 5; id_rs1 = 5; id_use_rs1 = 0;
    #1;
    chk("lu_nouse_d3", {26'd0, w_o3}, {26'd0, NONE});

    // ---- Redirect in the 2nd load-use cycle aborts the sequence ----
    id_use_rs1 = 1; id_pc = 32'h104;
    #1;
    chk("lur_c1_d3", {26'd0, w_o3}, {26'd0, STALL});
    step();
    ex_clear();
    ex_valid = 1; ex_is_ctrl = 1; ex_taken = 1; ex_target = 32'h200; ex_pc = 32'h100;
    #1;
    chk("lur_c2_d3", {26'd0, w_o3}, {26'd0, REDIR});
    chk("lur_c2_pc", rpc3, 32'h200);
    step();
    ex_clear();
    #1;
    chk("lur_c3_d3", {26'd0, w_o3}, {26'd0, NONE});

    // ---- MC RAW: div x7 issuing, ID reads x7 ----
    ex_valid = 1; ex_is_mc = 1; ex_wen = 1; ex_rd = 7;
    id_rs1 = 7; id_use_rs1 = 1;
    #1;
    chk("mc_raw_issue", {26'd0, w_o1}, {26'd0, STALL});
    step();
    ex_clear();
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("mc_raw_busy%0d", i), {26'd0, w_o1}, {26'd0, STB});
      step();
    end
    chk("mc_raw_release", {26'd0, w_o1}, {26'd0, NONE});

    // ---- MC structural: ID mul with no register dependence ----
    ex_valid = 1; ex_is_mc = 1; ex_wen = 1; ex_rd = 9;
    id_rs1 = 3; id_is_mc = 1;
    #1;
    chk("mc_st_issue", {26'd0, w_o1}, {26'd0, STALL});
    step();
    ex_clear();
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("mc_st_busy%0d", i), {26'd0, w_o3}, {26'd0, STB});
      step();
    end
    chk("mc_st_release", {26'd0, w_o3}, {26'd0, NONE});

    // ---- MC busy, independent non-mc op; redirect keeps the op alive ----
    id_is_mc = 0;
    ex_valid = 1; ex_is_mc = 1; ex_wen = 1; ex_rd = 9;
    #1;
    chk("mc_ind_issue", {26'd0, w_o1}, {26'd0, NONE});
    step();
    ex_clear();
    #1;
    chk("mc_ind_busy", {26'd0, w_o1}, {26'd0, BUSY});
    step();
    ex_valid = 1; ex_is_ctrl = 1; ex_taken = 1; ex_target = 32'h300; ex_pc = 32'h100;
    #1;
    chk("mc_ind_redir", {26'd0, w_o1}, {26'd0, RDB});
    step();
    ex_clear();
    #1;
    chk("mc_ind_after", {26'd0, w_o1}, {26'd0, BUSY});
    step();
    step();
    chk("mc_ind_drain", {26'd0, w_o1}, {26'd0, NONE});

    // ---- MC op without write-back never RAW-stalls ----
    ex_valid = 1; ex_is_mc = 1; ex_wen = 0; ex_rd = 7; id_rs1 = 7;
    #1;
    chk("mc_nowen_issue", {26'd0, w_o1}, {26'd0, NONE});
    step();
    ex_clear();
    #1;
    chk("mc_nowen_busy", {26'd0, w_o1}, {26'd0, BUSY});
    for (int i = 0; i < 4; i++) step();
    chk("mc_nowen_drain", {26'd0, w_o1}, {26'd0, NONE});

    // ---- Redirect compare ----
    id_use_rs1 = 0; id_rs1 = 0; id_pc = 32'h104;
    ex_valid = 1; ex_is_ctrl = 1; ex_taken = 1; ex_target = 32'h80; ex_pc = 32'h100;
    #1;
    chk("br_taken", {26'd0, w_o1}, {26'd0, REDIR});
    chk("br_taken_pc", rpc1, 32'h80);
    ex_taken = 0;
    #1;
    chk("br_nt", {26'd0, w_o1}, {26'd0, NONE});
    chk("br_nt_pc", rpc1, 32'h104);
    id_valid = 0;
    #1;
    chk("br_nt_noid", {26'd0, w_o1}, {26'd0, REDIR});
    id_valid = 1; id_pc = 32'h0; ex_pc = 32'hFFFF_FFFC;
    #1;
    chk("br_wrap", {26'd0, w_o1}, {26'd0, NONE});
    chk("br_wrap_pc", rpc1, 32'h0);
    step();
    ex_clear();

    // ---- Reset mid LU_WAIT and mid MC countdown ----
    ex_valid = 1; ex_is_mc = 1; ex_wen = 1; ex_rd = 7; id_rs1 = 3; id_use_rs1 = 1;
    step();
    ex_clear();
    ex_valid = 1; ex_is_load = 1; ex_wen = 1; ex_rd = 5; id_rs1 = 5;
    step();
    ex_clear();
    #1;
    chk("rm_pre_d3", {26'd0, w_o3}, {26'd0, STB});
    rst = 1'b1;
    #1;
    chk("rm_rst_d3", {26'd0, w_o3}, {26'd0, NONE});
    chk("rm_rst_d1", {26'd0, w_o1}, {26'd0, NONE});
    step();
    rst = 1'b0;
    #1;
    chk("rm_post_d3", {26'd0, w_o3}, {26'd0, NONE});
    step();
    chk("rm_post2_d3", {26'd0, w_o3}, {26'd0, NONE});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_hazard_ctrl_mc
`default_nettype wire

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
Pipeline hazard controller for the 5-stage RV32 core. It is the parametrised successor to the current hazard unit and adds the following over it:
- configurable load-use latency;
- a scoreboard for one non-pipelined multi-cycle unit (mul/div), with RAW and structural stalls;
- x0 and operand-use qualification;
- branch/jump redirect that cancels in-flight stall sequences.

It sits beside the ID/EX stages and drives PC/IF-ID stall and the ID/EX flush controls.

Parameters:
XLEN, 32, data/PC width
REG_AW, 5, register index width
LOAD_LAT, 1, bubbles per load-use hazard (legal 1..7)
MC_LAT, 4, multi-cycle unit latency in cycles (legal 2..64)
PC_INC, 4, sequential PC increment

Ports:
clk  in  1  core clock
rst  in  1  reset; asynchronous, active-high
id_valid  in  1  ID holds a real instruction
id_rs1, id_rs2  in  REG_AW  ID source registers
id_use_rs1, id_use_rs2  in  1  ID actually reads rs1/rs2
id_is_mc  in  1  ID instruction needs the multi-cycle unit
id_pc  in  XLEN  PC of ID instruction
ex_valid  in  1  EX holds a real instruction
ex_rd  in  REG_AW  EX destination
ex_wen  in  1  EX writes rd
ex_is_load  in  1  EX is a load
ex_is_mc  in  1  EX issues to the multi-cycle unit this cycle
ex_is_ctrl  in  1  EX is branch/jal/jalr
ex_taken  in  1  branch resolved taken (1 for jumps)
ex_target  in  XLEN  resolved target
ex_pc  in  XLEN  PC of EX instruction
stall_pc, stall_id  out  1  hold PC / IF-ID register
flush_id, flush_ex  out  1  zero IF-ID / ID-EX register
redirect_valid  out  1  fetch must load redirect_pc
redirect_pc  out  XLEN  corrected fetch address
mc_busy  out  1  multi-cycle unit occupied

Behaviour:
- Reset (async, active-high): FSM to IDLE, lu_cnt=0, mc_busy=0, mc_cnt=0, mc_rd=0. While rst is high, every output is 0, including redirect_pc.
- Source match: rsN_hit(r) = id_valid & id_use_rsN & (id_rsN != 0) & (id_rsN == r). Register x0 never hazards.
- Load-use detect: ex_valid & ex_is_load & ex_wen & (rs1_hit(ex_rd) | rs2_hit(ex_rd)).
- Load-use FSM: states IDLE, LU_WAIT.
  - IDLE, on detect: stall_pc=stall_id=flush_ex=1. If LOAD_LAT>1, go to LU_WAIT with lu_cnt=LOAD_LAT-1.
  - LU_WAIT: stall_pc=stall_id=flush_ex=1 and lu_cnt decrements each cycle. Return to IDLE in the cycle lu_cnt==1.
  - With LOAD_LAT=1 the FSM never leaves IDLE, giving exactly one bubble.
- MC scoreboard, issue: on ex_valid & ex_is_mc & ~redirect_valid at a clock edge, set mc_busy=1, mc_cnt=MC_LAT-1, mc_rd=ex_rd if ex_wen, else mc_rd=0.
- MC scoreboard, countdown: mc_cnt decrements while busy. mc_busy clears on the edge where mc_cnt==0, so busy is high for exactly MC_LAT cycles.
- MC stalls: stall_pc=stall_id=flush_ex=1 when any of the following holds:
  - a RAW hit on the in-flight result: mc_busy & (rs1_hit(mc_rd) | rs2_hit(mc_rd)) with mc_rd!=0;
  - a RAW hit on an op issuing now: ex_valid & ex_is_mc & ex_wen & a hit on ex_rd;
  - a structural conflict: id_valid & id_is_mc & (mc_busy | (ex_valid & ex_is_mc)).
  - A dependent instruction proceeds in the first cycle mc_busy=0; the result is on the forwarding path then.
- Redirect:
  - actual = ex_taken ? ex_target : ex_pc + PC_INC, computed mod 2^XLEN with wrap at 0xFFFFFFFC.
  - When ex_valid & ex_is_ctrl & (~id_valid | actual != id_pc): redirect_valid=1, redirect_pc=actual, flush_id=flush_ex=1, stall_pc=stall_id=0.
  - Otherwise redirect_pc=actual and redirect_valid=0.
  - redirect_valid is single-cycle and combinational.
- Priority: redirect beats all stalls.
  - A redirect forces the FSM to IDLE and lu_cnt to 0.
  - A redirect does not clear an in-flight mc op, which is older than the branch and must complete.
- Multiple stall sources assert the same outputs once (OR). A load-use and an MC stall in the same cycle need no extra cycles.
- Reset mid-sequence aborts LU_WAIT and the MC countdown immediately.

Decomposition:
- Package hazard_pkg holds:
  - FSM enum lu_state_e {IDLE, LU_WAIT};
  - opcode constants OP_LOAD=7'b0000011 and OP_BRANCH_GRP=3'b110 for decoders feeding this block;
  - the default PC_INC.
- One natural sub-module: mc_scoreboard (busy flag, counter, mc_rd, RAW/structural hit logic).
- The load-use FSM and redirect compare stay in the top.

Test Plan:
- LOAD_LAT=1, EX load rd=5, ID add rs1=5 -> one cycle stall_pc=stall_id=flush_ex=1, then all 0. The same case with rd=0 gives no stall.
- LOAD_LAT=3, same hazard -> stall/flush_ex high for exactly 3 consecutive cycles. A redirect in the 2nd cycle drops the stall that cycle and the FSM is in IDLE next cycle.
- MC_LAT=4, EX div rd=7 issues, ID reads x7 -> mc_busy high for 4 cycles and stall held through all of them. Release occurs in the first cycle mc_busy=0.
- mc_busy=1, ID mul with no register dependence -> structural stall until busy clears. With id_is_mc=0 and no dependence -> no stall.
- EX beq ex_pc=0x100, taken, target 0x80, id_pc=0x104 -> redirect_valid=1, redirect_pc=0x80, flush_id=flush_ex=1. Not-taken with id_pc=0x104 -> no redirect. ex_pc=0xFFFFFFFC not-taken with id_pc=0x0 -> no redirect (wrap).
- Assert rst for 1 cycle mid LU_WAIT and mid mc countdown -> all outputs 0 immediately. After release the block is idle with mc_busy=0.
